// File: rtl/snake_step_scheduler.sv
// Move pacing for the snake game: one move request per tick period, reversal-safe
// direction latching, score keeping and per-food tick speedup.
module snake_step_scheduler #(
    parameter int CNT_W        = 26,
    parameter int TICKS_NORMAL = 25_000_000,
    parameter int TICKS_HARD   = 12_500_000,
    parameter int SPEEDUP      = 500_000,
    parameter int MIN_TICKS    = 4_000_000,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stage,
    input  logic               difficulty,
    input  logic               btn_up_n,
    input  logic               btn_right_n,
    input  logic               btn_down_n,
    input  logic               btn_left_n,
    input  logic               step_done,
    input  logic               food_collision,
    input  logic               game_over,
    output logic               step_req,
    output logic [1:0]         dir,
    output logic [SCORE_W-1:0] score,
    output logic [CNT_W-1:0]   period
);

    localparam logic [CNT_W-1:0]   NORMAL_C  = CNT_W'(TICKS_NORMAL);
    localparam logic [CNT_W-1:0]   HARD_C    = CNT_W'(TICKS_HARD);
    localparam logic [CNT_W-1:0]   SPEEDUP_C = CNT_W'(SPEEDUP);
    localparam logic [CNT_W-1:0]   MIN_C     = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ZERO = SCORE_W'(0);
    localparam logic [1:0]         DIR_UP    = 2'b00;
    localparam logic [1:0]         DIR_RIGHT = 2'b01;
    localparam logic [1:0]         DIR_DOWN  = 2'b10;
    localparam logic [1:0]         DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_TICK = 2'b01,
        REQ       = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           dir_q, dir_d;
    logic [1:0]           pend_dir_q, pend_dir_d;
    logic                 step_req_q, step_req_d;
    logic [2:0]           cand_s;
    logic                 abort_s;

    // Returns {valid, direction} for the highest-priority pressed button.
    function automatic logic [2:0] pick_button(input logic up_n, input logic right_n,
                                               input logic down_n, input logic left_n);
        logic [2:0] r;
        if (!up_n) begin
            r = {1'b1, DIR_UP};
        end else if (!right_n) begin
            r = {1'b1, DIR_RIGHT};
        end else if (!down_n) begin
            r = {1'b1, DIR_DOWN};
        end else if (!left_n) begin
            r = {1'b1, DIR_LEFT};
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Shortened period, clamped at the floor without unsigned wraparound.
    function automatic logic [CNT_W-1:0] faster_period(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] r;
        if ((p > SPEEDUP_C) && ((p - SPEEDUP_C) > MIN_C)) begin
            r = p - SPEEDUP_C;
        end else begin
            r = MIN_C;
        end
        return r;
    endfunction

    // Next-state, counter, direction, score and period logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        score_d    = score_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        step_req_d = 1'b0;
        cand_s     = pick_button(btn_up_n, btn_right_n, btn_down_n, btn_left_n);
        abort_s    = !stage || game_over;

        // A reversal is judged against the committed direction, not the pending one.
        if ((state_q != IDLE) && cand_s[2] && (cand_s[1:0] != (dir_q ^ 2'b10))) begin
            pend_dir_d = cand_s[1:0];
        end else begin
            pend_dir_d = pend_dir_q;
        end

        case (state_q)
            IDLE: begin
                if (stage && !game_over) begin
                    state_d    = WAIT_TICK;
                    cnt_d      = CNT_ZERO;
                    score_d    = SCORE_ZERO;
                    dir_d      = DIR_RIGHT;
                    pend_dir_d = DIR_RIGHT;
                    period_d   = difficulty ? HARD_C : NORMAL_C;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_TICK: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (cnt_q == (period_q - CNT_ONE)) begin
                    state_d = REQ;
                    cnt_d   = CNT_ZERO;
                    dir_d   = pend_dir_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REQ: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (step_done) begin
                    state_d = WAIT_TICK;
                    if (food_collision) begin
                        score_d  = (score_q != SCORE_MAX) ? (score_q + SCORE_ONE) : score_q;
                        period_d = faster_period(period_q);
                    end else begin
                        score_d  = score_q;
                        period_d = period_q;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        step_req_d = (state_d == REQ);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            period_q   <= NORMAL_C;
            score_q    <= SCORE_ZERO;
            dir_q      <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            score_q    <= score_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            step_req_q <= step_req_d;
        end
    end

    assign step_req = step_req_q;
    assign dir      = dir_q;
    assign score    = score_q;
    assign period   = period_q;

endmodule
